// File: rtl/hdd_port.sv
// hdd_port: HDD-side responder with a 4-entry posted write buffer, forwarded reads and a transfer-tracking FSM.
// Latency: read data 1 cycle after the address edge; a posted write reaches the array when it becomes the oldest entry.
// Backpressure: hdd_busy while full; excess writes are dropped and flagged. HDD_PORT_WPROT_EN enables the write-protected region.
module hdd_port #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [15:0] WP_LIMIT   = 16'h0040
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] hdd_addr,
  input  logic [31:0] hdd_wb_data,
  input  logic        hdd_wb_flag,
  input  logic [1:0]  cp_flag,
  output logic [31:0] hdd_data,
  output logic        hdd_busy,
  output logic        xfer_done,
  output logic [15:0] xfer_words,
  output logic        wr_overflow,
  output logic        wr_protect_hit
);

`ifdef HDD_PORT_WPROT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  logic [31:0]           mem [0:(2**DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] buf_addr [4];
  logic [31:0]           buf_data [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            count, count_next;
  state_t                state;

  logic [DEPTH_LOG2-1:0] waddr;
  logic                  pop, push, drop, wp_block;
  logic [31:0]           rd_val;
  logic                  unused_addr;

  assign waddr       = hdd_addr[DEPTH_LOG2-1:0];
  assign unused_addr = ^hdd_addr;
  assign pop         = (count != 3'd0);
  assign wp_block    = WP_EN && hdd_wb_flag && (32'(waddr) < 32'(WP_LIMIT));
  assign push        = hdd_wb_flag && !wp_block && ((count < 3'd4) || pop);
  assign drop        = hdd_wb_flag && !wp_block && !push;
  assign count_next  = count + 3'(push) - 3'(pop);

  // Walk oldest to newest so the newest matching entry overrides older ones and the array.
  always_comb begin
    logic [1:0] idx;
    rd_val = mem[waddr];
    idx    = rd_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = rd_ptr + 2'(i);
      if ((3'(i) < count) && (buf_addr[idx] == waddr))
        rd_val = buf_data[idx];
    end
  end

  // Storage is not reset; count is, so a reset discards pending entries.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_addr[wr_ptr] <= waddr;
      buf_data[wr_ptr] <= hdd_wb_data;
    end
    if (pop)
      mem[buf_addr[rd_ptr]] <= buf_data[rd_ptr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr         <= 2'd0;
      rd_ptr         <= 2'd0;
      count          <= 3'd0;
      hdd_data       <= 32'd0;
      hdd_busy       <= 1'b0;
      xfer_done      <= 1'b0;
      xfer_words     <= 16'd0;
      wr_overflow    <= 1'b0;
      wr_protect_hit <= 1'b0;
      state          <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count    <= count_next;
      hdd_busy <= (count_next == 3'd4);
      hdd_data <= rd_val;
      if (drop)     wr_overflow    <= 1'b1;
      if (wp_block) wr_protect_hit <= 1'b1;
      xfer_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cp_flag == 2'd1) begin
            state      <= ACTIVE;
            xfer_words <= 16'd0;
          end
        end
        ACTIVE: begin
          if (push && (xfer_words != 16'hFFFF)) xfer_words <= xfer_words + 16'd1;
          if (cp_flag == 2'd2)      state <= DRAIN;
          else if (cp_flag == 2'd0) state <= IDLE;
        end
        DRAIN: begin
          if (push && (xfer_words != 16'hFFFF)) xfer_words <= xfer_words + 16'd1;
          if (count_next == 3'd0) begin
            state     <= DONE;
            xfer_done <= 1'b1;
          end
        end
        DONE: begin
          if (cp_flag == 2'd0) begin
            state <= IDLE;
          end else if (cp_flag == 2'd1) begin
            state      <= ACTIVE;
            xfer_words <= 16'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdd_port.sv
// Bench for hdd_port: directed scenarios with literal expectations plus randomized traffic against a queue-based model.
module tb_hdd_port;

`ifdef HDD_PORT_WPROT_EN
  localparam bit          WPROT = 1'b1;
  localparam logic [15:0] LB    = 16'h0100;
`else
  localparam bit          WPROT = 1'b0;
  localparam logic [15:0] LB    = 16'h0000;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] hdd_addr = 16'd0;
  logic [31:0] hdd_wb_data = 32'd0;
  logic        hdd_wb_flag = 1'b0;
  logic [1:0]  cp_flag = 2'd0;
  logic [31:0] hdd_data;
  logic        hdd_busy, xfer_done, wr_overflow, wr_protect_hit;
  logic [15:0] xfer_words;

  hdd_port dut (
    .clock(clock), .reset(reset), .hdd_addr(hdd_addr), .hdd_wb_data(hdd_wb_data),
    .hdd_wb_flag(hdd_wb_flag), .cp_flag(cp_flag), .hdd_data(hdd_data), .hdd_busy(hdd_busy),
    .xfer_done(xfer_done), .xfer_words(xfer_words), .wr_overflow(wr_overflow),
    .wr_protect_hit(wr_protect_hit)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes in front of a word array.
  typedef struct { int a; logic [31:0] d; } wr_t;
  wr_t         mq[$];
  logic [31:0] m_mem [0:1023];
  bit          m_known [0:1023];
  logic [31:0] m_data = 32'd0;
  bit          m_data_known = 1'b1;
  bit          m_busy = 0, m_done = 0, m_ovf = 0, m_wp = 0;
  logic [15:0] m_words = 16'd0;
  int          m_ph = 0;  // 0 idle, 1 copying, 2 draining, 3 finished

  always @(posedge clock or posedge reset) begin
    int w;
    logic [31:0] rv;
    bit rk, pushed, blocked;
    wr_t e;
    if (reset) begin
      mq.delete();
      m_data = 32'd0; m_data_known = 1'b1;
      m_busy = 0; m_done = 0; m_ovf = 0; m_wp = 0;
      m_words = 16'd0; m_ph = 0;
    end else begin
      w  = int'(hdd_addr) % 1024;
      rk = m_known[w];
      rv = m_mem[w];
      foreach (mq[i]) if (mq[i].a == w) begin rv = mq[i].d; rk = 1'b1; end
      m_data = rv; m_data_known = rk;
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_mem[e.a] = e.d; m_known[e.a] = 1'b1;
      end
      blocked = WPROT && hdd_wb_flag && (w < 'h40);
      if (blocked) m_wp = 1;
      pushed = 0;
      if (hdd_wb_flag && !blocked) begin
        if (mq.size() < 4) begin
          e.a = w; e.d = hdd_wb_data;
          mq.push_back(e);
          pushed = 1;
        end else m_ovf = 1;
      end
      m_done = 0;
      if ((m_ph == 1 || m_ph == 2) && pushed && m_words != 16'hFFFF) m_words = m_words + 16'd1;
      if (m_ph == 0) begin
        if (cp_flag == 2'd1) begin m_ph = 1; m_words = 16'd0; end
      end else if (m_ph == 1) begin
        if (cp_flag == 2'd2) m_ph = 2; else if (cp_flag == 2'd0) m_ph = 0;
      end else if (m_ph == 2) begin
        if (mq.size() == 0) begin m_ph = 3; m_done = 1; end
      end else begin
        if (cp_flag == 2'd0) m_ph = 0;
        else if (cp_flag == 2'd1) begin m_ph = 1; m_words = 16'd0; end
      end
      m_busy = (mq.size() == 4);
    end
  end

  always @(negedge clock) begin
    if (m_data_known) chk("hdd_data", hdd_data, m_data);
    chk("hdd_busy", 32'(hdd_busy), 32'(m_busy));
    chk("xfer_done", 32'(xfer_done), 32'(m_done));
    chk("xfer_words", 32'(xfer_words), 32'(m_words));
    chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
    chk("wr_protect_hit", 32'(wr_protect_hit), 32'(m_wp));
    if (xfer_done) done_cnt++;
  end

  task automatic drive(input logic f, input logic [15:0] a, input logic [31:0] d, input logic [1:0] c);
    hdd_wb_flag = f; hdd_addr = a; hdd_wb_data = d; cp_flag = c;
    @(negedge clock);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_data"}, hdd_data, 32'd0);
    chk({nm, "_busy"}, 32'(hdd_busy), 32'd0);
    chk({nm, "_done"}, 32'(xfer_done), 32'd0);
    chk({nm, "_words"}, 32'(xfer_words), 32'd0);
    chk({nm, "_ovf"}, 32'(wr_overflow), 32'd0);
    chk({nm, "_wp"}, 32'(wr_protect_hit), 32'd0);
  endtask

  initial begin
    int d0;
    logic [1:0]  rcp;
    logic [15:0] a;

    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    #2 reset = 1'b0;

    // Write then read the same address: served from the buffer.
    drive(1'b1, LB + 16'd5, 32'hDEADBEEF, 2'd0);
    drive(1'b0, LB + 16'd5, 32'd0, 2'd0);
    chk("fwd_read", hdd_data, 32'hDEADBEEF);

    // Upper address bits alias.
    drive(1'b1, LB + 16'h0403, 32'h0000_1234, 2'd0);
    drive(1'b0, LB + 16'h0003, 32'd0, 2'd0);
    chk("alias_read", hdd_data, 32'h0000_1234);

    // Back-to-back writes to one address: newest wins, no overflow.
    drive(1'b1, LB + 16'd9, 32'h0000_AAAA, 2'd0);
    drive(1'b1, LB + 16'd9, 32'h0000_BBBB, 2'd0);
    drive(1'b0, LB + 16'd9, 32'd0, 2'd0);
    chk("newest_wins", hdd_data, 32'h0000_BBBB);
    chk("no_overflow", 32'(wr_overflow), 32'd0);

    // Full transfer of 8 words.
    drive(1'b0, 16'd0, 32'd0, 2'd1);
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h0100 + 16'(i), 32'hC0DE_0000 + 32'(i), 2'd1);
    chk("xfer_words_8", 32'(xfer_words), 32'd8);
    d0 = done_cnt;
    drive(1'b0, 16'd0, 32'd0, 2'd2);
    chk("done_not_yet", 32'(xfer_done), 32'd0);
    drive(1'b0, 16'd0, 32'd0, 2'd2);
    chk("done_pulse", 32'(xfer_done), 32'd1);
    repeat (3) drive(1'b0, 16'd0, 32'd0, 2'd0);
    chk("xfer_words_hold", 32'(xfer_words), 32'd8);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 16'h0100 + 16'(i), 32'd0, 2'd0);
      chk("xfer_readback", hdd_data, 32'hC0DE_0000 + 32'(i));
    end

    // Abort then reset mid-stream with a write still buffered.
    d0 = done_cnt;
    drive(1'b0, 16'd0, 32'd0, 2'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, LB + 16'h20 + 16'(i), 32'h5000 + 32'(i), 2'd1);
    chk("abort_words", 32'(xfer_words), 32'd3);
    drive(1'b1, LB + 16'h30, 32'h5555, 2'd0);
    hdd_wb_flag = 1'b0;
    #2 reset = 1'b1;
    #1 chk_all_zero("midreset");
    @(negedge clock);
    #2 reset = 1'b0;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef HDD_PORT_WPROT_EN
    drive(1'b0, 16'd0, 32'd0, 2'd1);
    drive(1'b1, LB + 16'h50, 32'h7777, 2'd1);
    drive(1'b1, 16'h0010, 32'h6666, 2'd1);
    chk("wp_hit", 32'(wr_protect_hit), 32'd1);
    chk("wp_words", 32'(xfer_words), 32'd1);
`endif

    rcp = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rcp = 2'($urandom_range(0, 3));
      a = LB + 16'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a | 16'h0400;
      if (WPROT && $urandom_range(0, 9) == 0) a = 16'h0010;
      if ($urandom_range(0, 599) == 0) begin
        hdd_wb_flag = 1'b0;
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
      end
      drive(1'($urandom_range(0, 4) < 3), a, $urandom, rcp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
